cp2_divider: RTL and testbench

- Coprocessor-2 responder on the CPU's CP2 slot: data_in, addr, write_en in; data_out, interrupt out.
- CPU is the initiator and writes operands plus a start command.
- Block runs an iterative 32-bit restoring divide, signed or unsigned, in 34 cycles.
- Exposes quotient, remainder and status; raises a level interrupt on completion, which the CPU routes into its interrupt input (CP2 ready bit).

---
 rtl/cp2_pkg.sv | 26 ++
 rtl/div_core.sv | 53 +++++
 rtl/cp2_divider.sv | 166 ++++++++++++++++
 tb/tb_cp2_divider.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cp2_pkg.sv
// Shared definitions for the CP2 divider: register map, CTRL/STATUS bit positions, FSM states.
package cp2_pkg;

    localparam logic [4:0] CP2_DIVIDEND = 5'd0;
    localparam logic [4:0] CP2_DIVISOR  = 5'd1;
    localparam logic [4:0] CP2_CTRL     = 5'd2;
    localparam logic [4:0] CP2_STATUS   = 5'd3;
    localparam logic [4:0] CP2_QUOT     = 5'd4;
    localparam logic [4:0] CP2_REM      = 5'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_DBZ  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/div_core.sv
// Unsigned iterative restoring divider: one quotient bit per step, ITER steps after load.
module div_core #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             last_o
);

    localparam int CNT_W = $clog2(ITER);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   shifted, diff;
    logic             no_borrow;

    // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
    always_comb begin
        shifted   = {rem_q, quo_q[WIDTH-1]};
        diff      = shifted - {1'b0, dvs_q};
        no_borrow = ~diff[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
            cnt_q <= '0;
        end else if (step_i) begin
            rem_q <= no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], no_borrow};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign last_o      = (cnt_q == CNT_W'(ITER - 1));

endmodule

// File: rtl/cp2_divider.sv
// CP2 divide coprocessor: register bank, sign handling, sequencing FSM and completion interrupt
// around the unsigned div_core engine.
module cp2_divider
    import cp2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [4:0]       addr,
    input  logic             write_en,
    output logic [WIDTH-1:0] data_out,
    output logic             interrupt
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q,  divisor_d;
    logic [WIDTH-1:0] quot_q,     quot_d;
    logic [WIDTH-1:0] rem_q,      rem_d;
    logic             signed_q,   signed_d;
    logic             irq_en_q,   irq_en_d;
    logic             done_q,     done_d;
    logic             dbz_q,      dbz_d;
    logic             qneg_q,     qneg_d;
    logic             rneg_q,     rneg_d;
    logic             irq_q,      irq_d;

    logic             start_wr, div_zero, busy;
    logic             core_load, core_step, core_last;
    logic [WIDTH-1:0] core_quo, core_rem;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign start_wr = write_en && (addr == CP2_CTRL) && data_in[CTRL_START];
    assign div_zero = (divisor_q == '0);

    div_core #(.WIDTH(WIDTH), .ITER(ITER)) u_core (
        .clk         (clk),
        .rst         (rst),
        .load_i      (core_load),
        .step_i      (core_step),
        .dividend_i  (neg_if(dividend_q, signed_q & dividend_q[WIDTH-1])),
        .divisor_i   (neg_if(divisor_q,  signed_q & divisor_q[WIDTH-1])),
        .quotient_o  (core_quo),
        .remainder_o (core_rem),
        .last_o      (core_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_wr) state_d = PREP;
            PREP:    state_d = div_zero ? IDLE : CALC;
            CALC:    if (core_last) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_load = (state_q == PREP);
        core_step = (state_q == CALC);
        busy      = (state_q != IDLE);
    end

    // Later assignments take priority, so a completion on the same edge as a W1C leaves done set.
    always_comb begin
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        signed_d   = signed_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        dbz_d      = dbz_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;

        if (write_en && addr == CP2_DIVIDEND) dividend_d = data_in;
        if (write_en && addr == CP2_DIVISOR)  divisor_d  = data_in;
        if (write_en && addr == CP2_STATUS && data_in[STAT_DONE]) done_d = 1'b0;

        if (write_en && addr == CP2_CTRL && state_q == IDLE) begin
            signed_d = data_in[CTRL_SIGNED];
            irq_en_d = data_in[CTRL_IRQ_EN];
            if (data_in[CTRL_START]) begin
                done_d = 1'b0;
                dbz_d  = 1'b0;
            end
        end

        if (state_q == PREP) begin
            qneg_d = signed_q & (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
            rneg_d = signed_q & dividend_q[WIDTH-1];
            if (div_zero) begin
                quot_d = '1;
                rem_d  = dividend_q;
                dbz_d  = 1'b1;
                done_d = 1'b1;
            end
        end

        if (state_q == FIX) begin
            quot_d = neg_if(core_quo, qneg_q);
            rem_d  = neg_if(core_rem, rneg_q);
            done_d = 1'b1;
        end

        irq_d = done_d & irq_en_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            signed_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            signed_q   <= signed_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        data_out = '0;
        case (addr)
            CP2_DIVIDEND: data_out = dividend_q;
            CP2_DIVISOR:  data_out = divisor_q;
            CP2_CTRL:     data_out = {{(WIDTH-3){1'b0}}, irq_en_q, signed_q, 1'b0};
            CP2_STATUS:   data_out = {{(WIDTH-3){1'b0}}, dbz_q, done_q, busy};
            CP2_QUOT:     data_out = quot_q;
            CP2_REM:      data_out = rem_q;
            default:      data_out = '0;
        endcase
    end

    assign interrupt = irq_q;

endmodule

// File: tb/tb_cp2_divider.sv
// Directed bench for cp2_divider: register access, signed/unsigned divide, divide-by-zero,
// busy protection, W1C and mid-operation reset.
`timescale 1ns/1ps
module tb_cp2_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic [4:0]  addr;
    logic        write_en;
    logic [31:0] data_out;
    logic        interrupt;

    int checks   = 0;
    int failures = 0;

    cp2_divider dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .addr      (addr),
        .write_en  (write_en),
        .data_out  (data_out),
        .interrupt (interrupt)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        addr     = a;
        data_in  = d;
        write_en = 1'b1;
        tick(1);
        write_en = 1'b0;
        data_in  = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, data_out, exp);
    endtask

    initial begin
        rst = 1'b1; data_in = '0; addr = '0; write_en = 1'b0;
        tick(2);
        for (int a = 0; a < 8; a++) chk_reg("reset_reg", 5'(a), 32'h0);
        check("reset_irq", {31'b0, interrupt}, 32'h0);
        rst = 1'b0;
        tick(1);

        // Unmapped address and read-only registers ignore writes
        wr(5'd6, 32'hDEADBEEF);
        wr(5'd4, 32'h12345678);
        chk_reg("unmapped_rd", 5'd6, 32'h0);
        chk_reg("quot_ro", 5'd4, 32'h0);

        // Unsigned 100 / 7 with interrupt enabled
        wr(5'd0, 32'd100);
        wr(5'd1, 32'd7);
        wr(5'd2, 32'h5);                       // E0
        chk_reg("u_busy_e0", 5'd3, 32'h1);
        chk_reg("u_ctrl_rd", 5'd2, 32'h4);
        tick(33);                              // after E33
        chk_reg("u_busy_e33", 5'd3, 32'h1);
        check("u_irq_e33", {31'b0, interrupt}, 32'h0);
        tick(1);                               // after E34
        chk_reg("u_status", 5'd3, 32'h2);
        chk_reg("u_quot", 5'd4, 32'd14);
        chk_reg("u_rem", 5'd5, 32'd2);
        check("u_irq", {31'b0, interrupt}, 32'h1);

        // Signed -100 / 7, no interrupt
        wr(5'd0, 32'hFFFFFF9C);
        wr(5'd2, 32'h3);                       // E0
        check("s_irq_e0", {31'b0, interrupt}, 32'h0);
        chk_reg("s_status_e0", 5'd3, 32'h1);
        tick(34);
        chk_reg("s_quot", 5'd4, 32'hFFFFFFF2);
        chk_reg("s_rem", 5'd5, 32'hFFFFFFFE);
        chk_reg("s_status", 5'd3, 32'h2);
        check("s_irq", {31'b0, interrupt}, 32'h0);

        // Divide by zero
        wr(5'd0, 32'h1234);
        wr(5'd1, 32'h0);
        wr(5'd2, 32'h1);                       // E0
        chk_reg("z_busy", 5'd3, 32'h1);
        tick(1);                               // after E1
        chk_reg("z_status", 5'd3, 32'h6);
        chk_reg("z_quot", 5'd4, 32'hFFFFFFFF);
        chk_reg("z_rem", 5'd5, 32'h1234);

        // Signed overflow 0x80000000 / -1
        wr(5'd0, 32'h80000000);
        wr(5'd1, 32'hFFFFFFFF);
        wr(5'd2, 32'h3);
        tick(34);
        chk_reg("o_status", 5'd3, 32'h2);
        chk_reg("o_quot", 5'd4, 32'h80000000);
        chk_reg("o_rem", 5'd5, 32'h0);

        // Start and operand write while busy must not disturb the running divide
        wr(5'd0, 32'd100);
        wr(5'd1, 32'd7);
        wr(5'd2, 32'h5);                       // E0
        tick(9);                               // after E9
        wr(5'd2, 32'h3);                       // E10: ignored start with signed bit
        wr(5'd0, 32'd5);                       // E11
        tick(23);                              // after E34
        chk_reg("b_quot", 5'd4, 32'd14);
        chk_reg("b_rem", 5'd5, 32'd2);
        chk_reg("b_status", 5'd3, 32'h2);
        chk_reg("b_ctrl", 5'd2, 32'h4);
        chk_reg("b_dividend", 5'd0, 32'd5);
        check("b_irq", {31'b0, interrupt}, 32'h1);
        wr(5'd3, 32'h2);                       // W1C done
        chk_reg("w1c_status", 5'd3, 32'h0);
        check("w1c_irq", {31'b0, interrupt}, 32'h0);

        // Reset in the middle of an operation
        wr(5'd0, 32'd100);
        wr(5'd2, 32'h5);                       // E0
        tick(14);                              // after E14
        rst = 1'b1;
        tick(1);                               // E15
        rst = 1'b0;
        chk_reg("r_status", 5'd3, 32'h0);
        chk_reg("r_quot", 5'd4, 32'h0);
        chk_reg("r_dividend", 5'd0, 32'h0);
        check("r_irq", {31'b0, interrupt}, 32'h0);
        tick(25);                              // after E40
        chk_reg("r_status_e40", 5'd3, 32'h0);
        chk_reg("r_quot_e40", 5'd4, 32'h0);
        check("r_irq_e40", {31'b0, interrupt}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
